uart_tx_fifo: RTL and testbench

Buffered 8N1 UART transmitter. It is the transmit-side counterpart of the sniffer's UART receiver.
- Upstream logic pushes bytes into an internal FIFO with a write strobe.
- The block serialises the bytes LSB-first on Tx at BAUDS clock cycles per bit.
- It sits between the USB3300 capture path and the ICEstick FTDI serial line. It exposes full/empty flags that mirror the receiver's.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_sync_fifo.sv | 77 +++++++
 rtl/uart_tx_fifo.sv | 134 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants, frame bit values and transmitter FSM encoding (used by rx and tx).
package uart_pkg;

  localparam int DATA_BITS     = 8;
  localparam logic START_BIT   = 1'b0;
  localparam logic STOP_BIT    = 1'b1;
  localparam int BAUDS_DEFAULT = 104;

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = TX_IDLE,
    S_START = TX_START,
    S_DATA  = TX_DATA,
    S_STOP  = TX_STOP
  } tx_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Register FIFO, 2**AW entries, registered full/empty, sticky overflow; head visible combinationally.
// Writes while full are dropped; pops while empty are ignored, so an empty FIFO never pops its own write.
module uart_sync_fifo #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty,
  output logic          ovf
);

  localparam int DEPTH_N = 2 ** AW;
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [DW-1:0] mem_q [DEPTH_N];
  logic [DW-1:0] mem_d [DEPTH_N];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q, full_d, empty_q, empty_d, ovf_q, ovf_d;
  logic          wr_ok, rd_ok;

  always_comb begin
    wr_ok    = wr_en & ~full_q;
    rd_ok    = rd_en & ~empty_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (rd_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == DEPTH);
    empty_d = (count_d == '0);
    ovf_d   = ovf_q | (wr_en & full_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH_N; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = full_q;
  assign empty   = empty_q;
  assign ovf     = ovf_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a write into an idle, empty block starts the line one cycle later.
// Frames are 10*BAUDS cycles, sent back-to-back while the FIFO has data; writes while full are dropped.
module uart_tx_fifo #(
  parameter int BAUDS   = uart_pkg::BAUDS_DEFAULT,
  parameter int FIFO_AW = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] I_DATA,
  input  logic       WR,
  output logic       Tx,
  output logic       clk_Tx,
  output logic       BUSY,
  output logic       Tx_FULL,
  output logic       Tx_EMPTY,
  output logic       O_OVF
);
  import uart_pkg::*;

  localparam int CW = (BAUDS > 1) ? $clog2(BAUDS) : 1;
  localparam logic [CW-1:0] BAUD_MAX = CW'(BAUDS - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  tx_state_t      state_q, state_d;
  logic [CW-1:0]  baud_cnt_q, baud_cnt_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           tx_q, tx_d, busy_q, busy_d, clk_tx_q, clk_tx_d;
  logic           pop, baud_tick;
  logic [7:0]     fifo_rd;
  logic           fifo_full, fifo_empty, fifo_ovf;

  uart_sync_fifo #(.AW(FIFO_AW), .DW(8)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (WR),
    .wr_data (I_DATA),
    .rd_en   (pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .ovf     (fifo_ovf)
  );

  assign baud_tick = (baud_cnt_q == BAUD_MAX);

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_tick ? '0 : baud_cnt_q + CW'(1);
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    clk_tx_d   = 1'b0;
    pop        = 1'b0;
    case (state_q)
      S_IDLE: begin
        baud_cnt_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_rd;
          tx_d    = START_BIT;
          busy_d  = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_tick) begin
          clk_tx_d  = 1'b1;
          tx_d      = shift_q[0];
          bit_cnt_d = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          clk_tx_d = 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            tx_d    = STOP_BIT;
            state_d = S_STOP;
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (baud_tick) begin
          clk_tx_d = 1'b1;
          // Chain straight into the next start bit so queued frames have no idle gap.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_rd;
            tx_d    = START_BIT;
            state_d = S_START;
          end else begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      clk_tx_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      clk_tx_q   <= clk_tx_d;
    end
  end

  assign Tx       = tx_q;
  assign clk_Tx   = clk_tx_q;
  assign BUSY     = busy_q;
  assign Tx_FULL  = fifo_full;
  assign Tx_EMPTY = fifo_empty;
  assign O_OVF    = fifo_ovf;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: queued expected bytes are checked by a line-decoding monitor.
module tb_uart_tx_fifo;

  localparam int B = 104;

  logic       clk, rst, wr;
  logic [7:0] i_data;
  logic       tx, clk_tx, busy, full, empty, ovf;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  bit mon_en = 1'b1;

  uart_tx_fifo #(.BAUDS(B), .FIFO_AW(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .I_DATA   (i_data),
    .WR       (wr),
    .Tx       (tx),
    .clk_Tx   (clk_tx),
    .BUSY     (busy),
    .Tx_FULL  (full),
    .Tx_EMPTY (empty),
    .O_OVF    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; the write is taken at the following posedge.
  task automatic push_byte(input logic [7:0] d, input bit accepted);
    wr     = 1'b1;
    i_data = d;
    if (accepted) exp_q.push_back(d);
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (busy !== 1'b0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", {31'b0, busy}, 32'd0);
    repeat (4) @(negedge clk);
  endtask

  // Monitor: decode each frame mid-bit and compare against the scoreboard.
  initial begin
    logic [9:0] f;
    forever begin
      @(negedge clk);
      if (mon_en && rst === 1'b0 && tx === 1'b0) begin
        for (int i = 0; i < 10; i++) begin
          repeat ((i == 0) ? B / 2 : B) @(negedge clk);
          f[i] = tx;
        end
        check("start_bit", {31'b0, f[0]}, 32'd0);
        check("stop_bit", {31'b0, f[9]}, 32'd1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame actual=%0h required=none", f[8:1]);
        end else begin
          check("rx_byte", {24'b0, f[8:1]}, {24'b0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_low, low_cnt, busy_cnt, pulse_cnt, fall_cnt, high_cnt;
    logic prev_busy;
    logic [9:0] got;
    rst = 1'b1; wr = 1'b0; i_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_tx", {31'b0, tx}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_clk_tx", {31'b0, clk_tx}, 32'd0);
    check("rst_empty", {31'b0, empty}, 32'd1);
    check("rst_full", {31'b0, full}, 32'd0);
    check("rst_ovf", {31'b0, ovf}, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Single 0xFF frame: only the start bit is low.
    push_byte(8'hFF, 1'b1);
    first_low = -1; low_cnt = 0; busy_cnt = 0; pulse_cnt = 0;
    for (int j = 0; j < 1100; j++) begin
      if (tx === 1'b0) begin
        low_cnt++;
        if (first_low < 0) first_low = j;
      end
      if (busy === 1'b1) busy_cnt++;
      if (clk_tx === 1'b1) pulse_cnt++;
      @(negedge clk);
    end
    check("ff_first_low", first_low, 32'd1);
    check("ff_low_cycles", low_cnt, 32'd104);
    check("ff_busy_cycles", busy_cnt, 32'd1040);
    check("ff_clk_tx_pulses", pulse_cnt, 32'd10);
    wait_idle(200);

    // 0x69 bit pattern, LSB first, framed.
    push_byte(8'h69, 1'b1);
    check("69_empty_after_write", {31'b0, empty}, 32'd0);
    @(negedge clk);
    check("69_empty_after_pop", {31'b0, empty}, 32'd1);
    repeat (B / 2) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      got[i] = tx;
      if (i < 9) repeat (B) @(negedge clk);
    end
    check("69_line_bits", {22'b0, got}, {22'b0, 10'b1011010010});
    wait_idle(2000);

    // Three back-to-back frames; busy window seen from the third write onward.
    push_byte(8'hAF, 1'b1);
    push_byte(8'h12, 1'b1);
    push_byte(8'h55, 1'b1);
    busy_cnt = 0; fall_cnt = 0; prev_busy = busy;
    for (int j = 0; j < 3200; j++) begin
      if (busy === 1'b1) busy_cnt++;
      if (prev_busy === 1'b1 && busy === 1'b0) fall_cnt++;
      prev_busy = busy;
      @(negedge clk);
    end
    // Busy rose one negedge before this window began: 3120 total.
    check("b2b_busy_cycles", busy_cnt, 32'd3119);
    check("b2b_busy_falls", fall_cnt, 32'd1);
    wait_idle(200);

    // Overflow: 0x00 to shifter, 0x01..0x10 fill the FIFO, 0x11 dropped.
    for (int k = 0; k < 17; k++) push_byte(8'(k), 1'b1);
    check("ovf_full", {31'b0, full}, 32'd1);
    check("ovf_before_drop", {31'b0, ovf}, 32'd0);
    push_byte(8'h11, 1'b0);
    check("ovf_set", {31'b0, ovf}, 32'd1);
    check("ovf_full_after_drop", {31'b0, full}, 32'd1);
    wait_idle(20000);
    check("ovf_sticky", {31'b0, ovf}, 32'd1);
    check("ovf_drained_empty", {31'b0, empty}, 32'd1);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    // Reset in data bit 3 with two bytes queued.
    mon_en = 1'b0;
    push_byte(8'hFF, 1'b0);
    push_byte(8'hA1, 1'b0);
    push_byte(8'hB2, 1'b0);
    repeat (1 + 4 * B + 50 - 2) @(negedge clk);
    check("pre_rst_busy", {31'b0, busy}, 32'd1);
    check("pre_rst_empty", {31'b0, empty}, 32'd0);
    rst = 1'b1;
    #1;
    check("midrst_tx", {31'b0, tx}, 32'd1);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_empty", {31'b0, empty}, 32'd1);
    check("midrst_ovf", {31'b0, ovf}, 32'd0);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    high_cnt = 0; busy_cnt = 0;
    for (int j = 0; j < 2000; j++) begin
      @(negedge clk);
      if (tx === 1'b1) high_cnt++;
      if (busy === 1'b1) busy_cnt++;
    end
    check("post_rst_tx_high", high_cnt, 32'd2000);
    check("post_rst_busy", busy_cnt, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
